// File: rtl/reg_write_scheduler_if.sv
// Bus bundle for reg_write_scheduler.
//   A_*          pipeline writeback request (no back-pressure)
//   B_*          mul/div result request with B_READY handshake
//   MD_ISSUE/RD  mul/div issue and its destination; ISSUE_READY grants it
//   RS1_Q/RS2_Q/RD_Q, HAZARD  decode-stage scoreboard query and stall
//   PIPE_HOLD    request for the pipeline to bubble writeback
//   WR_*         register-file write port
//   ERR          sticky protocol-violation flag
// slave is the scheduler's view; master is the surrounding core's view.
interface reg_write_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              A_VALID;
  logic [4:0]        A_ADDR;
  logic [DATA_W-1:0] A_DATA;
  logic              B_VALID;
  logic [4:0]        B_ADDR;
  logic [DATA_W-1:0] B_DATA;
  logic              B_READY;
  logic              MD_ISSUE;
  logic [4:0]        MD_RD;
  logic              ISSUE_READY;
  logic [4:0]        RS1_Q;
  logic [4:0]        RS2_Q;
  logic [4:0]        RD_Q;
  logic              HAZARD;
  logic              PIPE_HOLD;
  logic              WR_EN;
  logic [4:0]        WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              ERR;

  modport slave (
    input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    input  MD_ISSUE, MD_RD, RS1_Q, RS2_Q, RD_Q,
    output B_READY, ISSUE_READY, HAZARD, PIPE_HOLD,
    output WR_EN, WR_ADDR, WR_DATA, ERR
  );

  modport master (
    output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA,
    output MD_ISSUE, MD_RD, RS1_Q, RS2_Q, RD_Q,
    input  B_READY, ISSUE_READY, HAZARD, PIPE_HOLD,
    input  WR_EN, WR_ADDR, WR_DATA, ERR
  );
endinterface

// File: rtl/reg_write_scheduler.sv
// reg_write_scheduler: arbitrates the single register-file write port between
// the pipeline writeback (A, always wins) and buffered mul/div results (B,
// 2-entry FIFO). Tracks outstanding mul/div destinations in a pending
// scoreboard for decode hazards, raises PIPE_HOLD when the FIFO head starves,
// and flags protocol violations on a sticky ERR.
// Ports:
//   CLK     clock, rising edge
//   RESETN  asynchronous active-low reset
//   bus     reg_write_scheduler_if.slave (A/B requests, issue, query, write port)
module reg_write_scheduler #(
  parameter int DATA_W = 32
) (
  input logic             CLK,
  input logic             RESETN,
  reg_write_scheduler_if.slave bus
);

  logic [4:0]        fifo_addr [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic [31:0]       pending;
  logic [31:0]       pending_nxt;
  logic [3:0]        age;
  logic [3:0]        age_nxt;
  logic              pipe_hold_q;
  logic              err_q;
  logic              err_nxt;
  logic              vld_p1;
  logic [4:0]        wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [4:0]        head_addr;
  logic [DATA_W-1:0] head_data;
  logic              issue_ok;
  logic              md_set;

  function automatic logic is_pending(input logic [4:0] q, input logic [31:0] p);
    return (q != 5'd0) && p[q];
  endfunction

  assign fifo_full  = (count == 2'd2);
  assign fifo_empty = (count == 2'd0);
  assign push       = bus.B_VALID && !fifo_full;
  // A always has priority; the FIFO head only drains on cycles A is idle.
  assign pop        = !bus.A_VALID && !fifo_empty;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign issue_ok   = (bus.MD_RD == 5'd0) || !pending[bus.MD_RD];
  assign md_set     = bus.MD_ISSUE && issue_ok && (bus.MD_RD != 5'd0);

  assign bus.B_READY     = !fifo_full;
  assign bus.ISSUE_READY = issue_ok;
  assign bus.HAZARD      = is_pending(bus.RS1_Q, pending) ||
                           is_pending(bus.RS2_Q, pending) ||
                           is_pending(bus.RD_Q, pending);
  assign bus.PIPE_HOLD   = pipe_hold_q;
  assign bus.ERR         = err_q;
  assign bus.WR_EN       = vld_p1;
  assign bus.WR_ADDR     = wr_addr_p1;
  assign bus.WR_DATA     = wr_data_p1;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase

    // Clear before set so a same-edge set on the same register wins.
    pending_nxt = pending;
    if (pop)    pending_nxt[head_addr] = 1'b0;
    if (md_set) pending_nxt[bus.MD_RD] = 1'b1;
    pending_nxt[0] = 1'b0;

    // Non-empty and not popped means the head waited this cycle.
    age_nxt = age;
    if (fifo_empty || pop)  age_nxt = 4'd0;
    else if (age != 4'hF)   age_nxt = age + 4'd1;

    err_nxt = err_q
            | (bus.MD_ISSUE && !issue_ok)
            | (bus.A_VALID && pipe_hold_q)
            | (push && (bus.B_ADDR != 5'd0) && !pending[bus.B_ADDR]);
  end

  // FIFO storage holds no control state, so it is left out of reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.B_ADDR;
      fifo_data[wr_ptr] <= bus.B_DATA;
    end
  end

  // Stage p0 -> p1: selected write registered onto the write port.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      pending     <= '0;
      age         <= 4'd0;
      pipe_hold_q <= 1'b0;
      err_q       <= 1'b0;
      vld_p1      <= 1'b0;
      wr_addr_p1  <= 5'd0;
      wr_data_p1  <= '0;
    end else begin
      count       <= count_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      pending     <= pending_nxt;
      age         <= age_nxt;
      // Sampled from the current age, so it falls one edge after the pop.
      pipe_hold_q <= (age >= 4'd8);
      err_q       <= err_nxt;
      if (bus.A_VALID) begin
        vld_p1     <= (bus.A_ADDR != 5'd0);
        wr_addr_p1 <= bus.A_ADDR;
        wr_data_p1 <= bus.A_DATA;
      end else if (pop) begin
        vld_p1     <= (head_addr != 5'd0);
        wr_addr_p1 <= head_addr;
        wr_data_p1 <= head_data;
      end else begin
        vld_p1     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Bench for reg_write_scheduler: directed scenarios followed by randomized
// traffic; a transaction-level model predicts each cycle's outputs into
// queues and an independent negedge monitor compares the DUT against them.
module tb_reg_write_scheduler;

  logic CLK = 1'b0;
  logic RESETN;
  always #5 CLK = ~CLK;

  reg_write_scheduler_if bus ();

  reg_write_scheduler dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  typedef struct { logic en; logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic b_ready; logic issue_ready; logic hazard; logic pipe_hold; logic err; } st_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;

  wr_t  wq[$];
  st_t  sq[$];

  // Reference model state
  ent_t     mq[$];
  bit [31:0] mpend;
  int       mwait;
  bit       mhold;
  bit       merr;
  wr_t      mwr;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    mpend = '0;
    mwait = 0;
    mhold = 1'b0;
    merr  = 1'b0;
    mwr   = '{1'b0, 5'd0, 32'd0};
  endfunction

  function automatic bit haz(logic [4:0] q);
    return (q != 5'd0) && mpend[q];
  endfunction

  // One clock edge of the specified behaviour, using the inputs held this cycle.
  function automatic void model_edge();
    bit   was_empty, ready, ok, popped;
    ent_t h;
    if (!RESETN) begin
      model_reset();
      return;
    end
    was_empty = (mq.size() == 0);
    ready     = (mq.size() < 2);
    ok        = (bus.MD_RD == 5'd0) || !mpend[bus.MD_RD];
    if (bus.MD_ISSUE && !ok) merr = 1'b1;
    if (bus.A_VALID && mhold) merr = 1'b1;
    if (bus.B_VALID && ready && bus.B_ADDR != 5'd0 && !mpend[bus.B_ADDR]) merr = 1'b1;
    popped = 1'b0;
    if (bus.A_VALID) begin
      mwr = '{bus.A_ADDR != 5'd0, bus.A_ADDR, bus.A_DATA};
    end else if (!was_empty) begin
      h = mq.pop_front();
      mwr = '{h.addr != 5'd0, h.addr, h.data};
      mpend[h.addr] = 1'b0;
      popped = 1'b1;
    end else begin
      mwr.en = 1'b0;
    end
    if (bus.B_VALID && ready) mq.push_back('{bus.B_ADDR, bus.B_DATA});
    if (bus.MD_ISSUE && ok && bus.MD_RD != 5'd0) mpend[bus.MD_RD] = 1'b1;
    mpend[0] = 1'b0;
    mhold = (mwait >= 8);
    if (popped || was_empty) mwait = 0;
    else mwait++;
  endfunction

  // Predict this cycle's outputs, then advance one edge.
  task automatic cycle();
    st_t s;
    if (!RESETN) model_reset();
    s.b_ready     = (mq.size() < 2);
    s.issue_ready = (bus.MD_RD == 5'd0) || !mpend[bus.MD_RD];
    s.hazard      = haz(bus.RS1_Q) || haz(bus.RS2_Q) || haz(bus.RD_Q);
    s.pipe_hold   = mhold;
    s.err         = merr;
    sq.push_back(s);
    wq.push_back(mwr);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.A_VALID  = 1'b0; bus.A_ADDR = 5'd0; bus.A_DATA = 32'd0;
    bus.B_VALID  = 1'b0; bus.B_ADDR = 5'd0; bus.B_DATA = 32'd0;
    bus.MD_ISSUE = 1'b0; bus.MD_RD  = 5'd0;
    bus.RS1_Q    = 5'd0; bus.RS2_Q  = 5'd0; bus.RD_Q   = 5'd0;
  endtask

  function automatic logic [4:0] pick_b_addr();
    logic [4:0] r;
    for (int k = 0; k < 6; k++) begin
      r = 5'($urandom_range(1, 31));
      if (mpend[r]) return r;
    end
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: compares DUT outputs with the predictions, decoupled from stimulus.
  st_t mon_s;
  wr_t mon_w;
  always @(negedge CLK) begin
    if (sq.size() > 0) begin
      mon_s = sq.pop_front();
      chk("b_ready",     32'(bus.B_READY),     32'(mon_s.b_ready));
      chk("issue_ready", 32'(bus.ISSUE_READY), 32'(mon_s.issue_ready));
      chk("hazard",      32'(bus.HAZARD),      32'(mon_s.hazard));
      chk("pipe_hold",   32'(bus.PIPE_HOLD),   32'(mon_s.pipe_hold));
      chk("err",         32'(bus.ERR),         32'(mon_s.err));
    end
    if (wq.size() > 0) begin
      mon_w = wq.pop_front();
      chk("wr_en", 32'(bus.WR_EN), 32'(mon_w.en));
      if (mon_w.en) begin
        chk("wr_addr", 32'(bus.WR_ADDR), 32'(mon_w.addr));
        chk("wr_data", bus.WR_DATA, mon_w.data);
      end
    end
  end

  initial begin
    model_reset();
    RESETN = 1'b0;
    idle();
    @(posedge CLK);
    #1;
    repeat (3) cycle();
    RESETN = 1'b1;
    cycle();

    // Single A write
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd5; bus.A_DATA = 32'hDEADBEEF;
    cycle();
    idle();
    repeat (2) cycle();

    // A write to register 0 is suppressed
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd0; bus.A_DATA = 32'h0BAD0BAD;
    cycle();
    idle();
    cycle();

    // Issue to r7, hazard, B result clears it
    bus.MD_ISSUE = 1'b1; bus.MD_RD = 5'd7;
    cycle();
    idle();
    bus.RS1_Q = 5'd7; bus.MD_RD = 5'd7;
    cycle();
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd7; bus.B_DATA = 32'h12;
    cycle();
    bus.B_VALID = 1'b0;
    repeat (3) cycle();
    idle();

    // A held high, three B beats: FIFO fills, then drains in order
    for (int k = 0; k < 3; k++) begin
      bus.MD_ISSUE = 1'b1; bus.MD_RD = 5'(3 + k);
      cycle();
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      bus.A_VALID = 1'b1;
      bus.A_ADDR  = 5'($urandom_range(1, 31));
      bus.A_DATA  = $urandom;
      bus.B_VALID = (k < 3);
      bus.B_ADDR  = 5'(3 + k);
      bus.B_DATA  = 32'h100 + 32'(k);
      cycle();
    end
    idle();
    repeat (4) cycle();

    // Starvation: one B entry waits behind continuous A traffic
    RESETN = 1'b0;
    cycle();
    RESETN = 1'b1;
    bus.MD_ISSUE = 1'b1; bus.MD_RD = 5'd9;
    cycle();
    idle();
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd9; bus.B_DATA = 32'hCAFE0009;
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd1; bus.A_DATA = 32'h1;
    cycle();
    bus.B_VALID = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.A_ADDR = 5'($urandom_range(1, 31));
      bus.A_DATA = $urandom;
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Reset with two entries queued discards them
    RESETN = 1'b0;
    cycle();
    RESETN = 1'b1;
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd2; bus.A_DATA = 32'h2;
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd14; bus.B_DATA = 32'hE;
    cycle();
    bus.B_ADDR = 5'd15; bus.B_DATA = 32'hF;
    cycle();
    bus.B_VALID = 1'b0;
    cycle();
    RESETN = 1'b0;
    idle();
    repeat (2) cycle();
    RESETN = 1'b1;
    repeat (3) cycle();

    // Same-edge clear and set on r12: set wins
    bus.A_VALID = 1'b1; bus.A_ADDR = 5'd3; bus.A_DATA = 32'h3;
    bus.B_VALID = 1'b1; bus.B_ADDR = 5'd12; bus.B_DATA = 32'hC;
    cycle();
    idle();
    bus.MD_ISSUE = 1'b1; bus.MD_RD = 5'd12;
    cycle();
    idle();
    bus.RS2_Q = 5'd12; bus.RD_Q = 5'd12; bus.MD_RD = 5'd12;
    repeat (2) cycle();
    idle();

    // Randomized traffic with periodic A bursts and resets
    RESETN = 1'b0;
    cycle();
    RESETN = 1'b1;
    for (int i = 0; i < 600; i++) begin
      RESETN       = (i % 200 != 199);
      bus.A_VALID  = ((i % 50) < 14) || ($urandom_range(0, 99) < 35);
      bus.A_ADDR   = 5'($urandom_range(0, 31));
      bus.A_DATA   = $urandom;
      bus.MD_ISSUE = ($urandom_range(0, 99) < 30);
      bus.MD_RD    = 5'($urandom_range(0, 31));
      bus.B_VALID  = ($urandom_range(0, 99) < 45);
      bus.B_ADDR   = pick_b_addr();
      bus.B_DATA   = $urandom;
      bus.RS1_Q    = pick_b_addr();
      bus.RS2_Q    = 5'($urandom_range(0, 31));
      bus.RD_Q     = 5'($urandom_range(0, 31));
      cycle();
    end
    RESETN = 1'b1;
    idle();
    repeat (4) cycle();

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
